// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle initiator: one valid/ready command becomes one bus cycle plus one response.
// Optional ack-timeout abort path enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] wbm_adr,
    output logic [31:0] wbm_wdata,
    output logic [3:0]  wbm_sel,
    output logic        wbm_cyc,
    output logic        wbm_stb,
    output logic        wbm_we,
    input  logic        wbm_ack,
    input  logic [31:0] wbm_rdata,
    output logic [15:0] txn_cnt
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t state, state_nxt;
    logic   cmd_fire;
    logic   bus_done;
    logic   timeout_hit;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    logic [15:0] to_cnt;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n)
            to_cnt <= '0;
        else if (cmd_fire)
            to_cnt <= '0;
        else if (state == BUS && !wbm_ack)
            to_cnt <= to_cnt + 16'd1;
    end

    assign timeout_hit = (state == BUS) && (to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    // Always false for any legal TIMEOUT_CYCLES; BUS waits for ack indefinitely.
    assign timeout_hit = (TIMEOUT_CYCLES == 0);
`endif

    assign cmd_fire = cmd_valid && cmd_ready;
    assign bus_done = (state == BUS) && (wbm_ack || timeout_hit);

    // cyc/stb/rsp_valid decode straight from state so reset clears them with no edge
    assign wbm_cyc   = (state == BUS);
    assign wbm_stb   = (state == BUS);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_nxt = BUS;
            end
            BUS: begin
                if (wbm_ack || timeout_hit)
                    state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wbm_adr   <= '0;
            wbm_wdata <= '0;
            wbm_sel   <= '0;
            wbm_we    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            txn_cnt   <= '0;
        end else begin
            if (cmd_fire) begin
                wbm_adr   <= cmd_adr;
                wbm_wdata <= cmd_wdata;
                wbm_sel   <= cmd_sel;
                wbm_we    <= cmd_we;
            end
            // ack takes priority over a coincident timeout
            if (bus_done) begin
                wbm_we    <= 1'b0;
                rsp_err   <= !wbm_ack;
                rsp_rdata <= wbm_ack ? (wbm_we ? 32'h0 : wbm_rdata) : ERR_RDATA;
            end
            if (rsp_valid && rsp_ready)
                txn_cnt <= txn_cnt + 16'd1;
        end
    end

endmodule
